// File: rtl/idma_obi_write_pkg.sv
// rtl/idma_obi_write_pkg.sv - shared types and constants for the iDMA OBI write port
package idma_obi_write_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefLenWidth  = 8;

  localparam int unsigned StrbWidth = DefDataWidth / 8;
  localparam int unsigned AddrLsb   = $clog2(StrbWidth);

  typedef logic [DefAddrWidth-1:0] addr_t;
  typedef logic [DefLenWidth-1:0]  len_t;
  typedef logic [StrbWidth-1:0]    strb_t;
  typedef logic [DefDataWidth-1:0] data_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } issue_state_e;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - synchronous FIFO, optional fall-through, sync active-low reset
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] LastPtr = ADDR_DEPTH'(DEPTH - 1);
  localparam logic [ADDR_DEPTH:0]   FullCnt = (ADDR_DEPTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_q, wr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic                  bypass, do_push, do_pop;

  always_comb begin
    bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
    do_push = push_i && (cnt_q != FullCnt) && !(bypass && pop_i);
    do_pop  = pop_i && (cnt_q != '0);
  end

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0) && !bypass;
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign data_o  = bypass ? data_i : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= (wr_q == LastPtr) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) rd_q <= (rd_q == LastPtr) ? '0 : rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/idma_obi_rsp_tracker.sv
// rtl/idma_obi_rsp_tracker.sv - matches OBI responses to transfers and queues one completion each
module idma_obi_rsp_tracker #(
  parameter int unsigned LenWidth     = 8,
  parameter int unsigned NumTransfers = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                aw_push_i,
  input  logic [LenWidth-1:0] aw_len_i,
  input  logic                rsp_valid_i,
  input  logic                rsp_err_i,
  output logic                w_rsp_valid_o,
  input  logic                w_rsp_ready_i,
  output logic                w_rsp_err_o,
  output logic                admit_o,
  output logic                pending_o
);

  localparam int unsigned FifoAw = (NumTransfers > 1) ? $clog2(NumTransfers) : 1;
  localparam int unsigned CntW   = $clog2(NumTransfers + 1) + 1;

  logic [LenWidth-1:0] rsp_cnt_q, rsp_cnt_d, len_head;
  logic                err_acc_q, err_acc_d;
  logic                len_full, len_empty, cpl_full, cpl_empty, last;
  logic [FifoAw-1:0]   len_usage, cpl_usage;
  logic [0:0]          cpl_head;
  logic [CntW-1:0]     len_cnt, cpl_cnt;

  assign last = rsp_valid_i && (rsp_cnt_q == len_head);

  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(LenWidth), .DEPTH(NumTransfers)) i_len_fifo (
    .clk_i, .rst_ni, .flush_i(1'b0),
    .full_o(len_full), .empty_o(len_empty), .usage_o(len_usage),
    .data_i(aw_len_i), .push_i(aw_push_i), .data_o(len_head), .pop_i(last)
  );

  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(1), .DEPTH(NumTransfers)) i_cpl_fifo (
    .clk_i, .rst_ni, .flush_i(1'b0),
    .full_o(cpl_full), .empty_o(cpl_empty), .usage_o(cpl_usage),
    .data_i(err_acc_q | rsp_err_i), .push_i(last), .data_o(cpl_head),
    .pop_i(w_rsp_valid_o & w_rsp_ready_i)
  );

  always_comb begin
    rsp_cnt_d = rsp_cnt_q;
    err_acc_d = err_acc_q;
    if (last) begin
      rsp_cnt_d = '0;
      err_acc_d = 1'b0;
    end else if (rsp_valid_i) begin
      rsp_cnt_d = rsp_cnt_q + 1'b1;
      err_acc_d = err_acc_q | rsp_err_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_cnt_q <= '0;
      err_acc_q <= 1'b0;
    end else begin
      rsp_cnt_q <= rsp_cnt_d;
      err_acc_q <= err_acc_d;
    end
  end

  // Full FIFOs report usage 0, so rebuild the true occupancy from full_o.
  assign len_cnt = len_full ? CntW'(NumTransfers) : CntW'(len_usage);
  assign cpl_cnt = cpl_full ? CntW'(NumTransfers) : CntW'(cpl_usage);

  assign admit_o       = (len_cnt + cpl_cnt) < CntW'(NumTransfers);
  assign pending_o     = !len_empty || !cpl_empty;
  assign w_rsp_valid_o = !cpl_empty;
  assign w_rsp_err_o   = cpl_head[0];

  a_no_cpl_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(last && cpl_full));

endmodule

// File: rtl/idma_obi_write_outstanding.sv
// rtl/idma_obi_write_outstanding.sv - OBI write port issuing one beat per grant with bounded outstanding beats
module idma_obi_write_outstanding
  import idma_obi_write_pkg::*;
#(
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned LenWidth        = 8,
  parameter int unsigned NumOutstanding  = 4,
  parameter int unsigned NumTransfers    = 2,
  parameter bit          MaskInvalidData = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [LenWidth-1:0]    aw_len_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [DataWidth-1:0]   buf_data_i,
  input  logic [DataWidth/8-1:0] buf_strb_i,
  input  logic                   buf_valid_i,
  output logic                   buf_ready_o,
  input  logic                   dp_poison_i,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  input  logic                   obi_rvalid_i,
  input  logic                   obi_err_i,
  output logic                   w_rsp_valid_o,
  input  logic                   w_rsp_ready_i,
  output logic                   w_rsp_err_o,
  output logic                   busy_o
);

  localparam int unsigned StrbBytes = DataWidth / 8;
  localparam int unsigned OutW      = $clog2(NumOutstanding + 1);
  localparam logic [AddrWidth-1:0] LowMask = AddrWidth'(StrbBytes - 1);

  issue_state_e        state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth-1:0]  beats_q, beats_d;
  logic [OutW-1:0]      outst_q, outst_d;
  logic                 grant, rsp_ok, aw_hs, admit, trk_pending;

  assign grant  = obi_req_o && obi_gnt_i;
  assign rsp_ok = obi_rvalid_i && (outst_q != '0);
  assign aw_hs  = aw_valid_i && aw_ready_o;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    aw_ready_o = 1'b0;
    obi_req_o  = 1'b0;
    case (state_q)
      IDLE: begin
        aw_ready_o = rst_ni && admit;
        if (aw_valid_i && aw_ready_o) begin
          addr_d  = aw_addr_i & ~LowMask;
          beats_d = aw_len_i;
          state_d = BURST;
        end
      end
      BURST: begin
        // A stalled request freezes outst_q, so once raised it stays up until granted.
        obi_req_o = rst_ni && buf_valid_i && (outst_q < OutW'(NumOutstanding));
        if (obi_req_o && obi_gnt_i) begin
          addr_d  = addr_q + AddrWidth'(StrbBytes);
          beats_d = beats_q - 1'b1;
          if (beats_q == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    case ({grant, rsp_ok})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      outst_q <= outst_d;
    end
  end

  assign buf_ready_o = grant;
  assign obi_we_o    = 1'b1;
  assign obi_addr_o  = addr_q;
  assign obi_wdata_o = (MaskInvalidData && !obi_req_o) ? '0 : buf_data_i;
  assign obi_be_o    = ((MaskInvalidData && !obi_req_o) || dp_poison_i) ? '0 : buf_strb_i;

  idma_obi_rsp_tracker #(
    .LenWidth    (LenWidth),
    .NumTransfers(NumTransfers)
  ) i_rsp_tracker (
    .clk_i,
    .rst_ni,
    .aw_push_i    (aw_hs),
    .aw_len_i     (aw_len_i),
    .rsp_valid_i  (rsp_ok),
    .rsp_err_i    (obi_err_i),
    .w_rsp_valid_o(w_rsp_valid_o),
    .w_rsp_ready_i(w_rsp_ready_i),
    .w_rsp_err_o  (w_rsp_err_o),
    .admit_o      (admit),
    .pending_o    (trk_pending)
  );

  assign busy_o = (state_q == BURST) || (outst_q != '0) || trk_pending;

  a_rvalid_with_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni) obi_rvalid_i |-> (outst_q != '0));

endmodule

// File: tb/tb_idma_obi_write_outstanding.sv
// tb/tb_idma_obi_write_outstanding.sv - directed bench for the iDMA OBI write port
module tb_idma_obi_write_outstanding;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic        aw_valid_i, aw_ready_o;
  logic [31:0] buf_data_i;
  logic [3:0]  buf_strb_i;
  logic        buf_valid_i, buf_ready_o, dp_poison_i;
  logic        obi_req_o, obi_gnt_i, obi_we_o;
  logic [31:0] obi_addr_o, obi_wdata_o;
  logic [3:0]  obi_be_o;
  logic        obi_rvalid_i, obi_err_i;
  logic        w_rsp_valid_o, w_rsp_ready_i, w_rsp_err_o, busy_o;

  always #5 clk = ~clk;

  idma_obi_write_outstanding dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .buf_data_i(buf_data_i), .buf_strb_i(buf_strb_i), .buf_valid_i(buf_valid_i), .buf_ready_o(buf_ready_o),
    .dp_poison_i(dp_poison_i),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i), .obi_err_i(obi_err_i),
    .w_rsp_valid_o(w_rsp_valid_o), .w_rsp_ready_i(w_rsp_ready_i), .w_rsp_err_o(w_rsp_err_o), .busy_o(busy_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hDEADBEEF ^ (32'(i) << 8);
  endfunction

  function automatic logic [3:0] spat(input int i);
    return (i % 3 == 1) ? 4'h3 : 4'hF;
  endfunction

  typedef struct {
    int   due;
    logic err;
  } pend_t;

  logic [31:0] gaddr[$];
  logic [31:0] gdata[$];
  logic [3:0]  gbe[$];
  logic        rsps[$];
  pend_t       pend[$];
  int          cyc = 0;
  int          err_at = -1;
  int          bidx = 0;
  int          rsp_budget = 0;
  bit          hold_rsp = 1'b0;
  bit          stray = 1'b0;

  // OBI subordinate and buffer model: logs grants, answers each beat two cycles later.
  initial begin : agent
    bit g;
    forever begin
      @(negedge clk);
      g = obi_req_o && obi_gnt_i;
      if (g) begin
        gaddr.push_back(obi_addr_o);
        gdata.push_back(obi_wdata_o);
        gbe.push_back(obi_be_o);
        pend.push_back('{cyc + 2, (int'(gaddr.size()) - 1 == err_at)});
      end
      if (w_rsp_valid_o && w_rsp_ready_i) rsps.push_back(w_rsp_err_o);
      @(posedge clk);
      #2;
      cyc++;
      if (g) begin
        bidx++;
        buf_data_i = pat(bidx);
        buf_strb_i = spat(bidx);
      end
      obi_rvalid_i = 1'b0;
      obi_err_i    = 1'b0;
      if (stray) begin
        obi_rvalid_i = 1'b1;
        stray        = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= cyc && (!hold_rsp || rsp_budget > 0)) begin
        if (hold_rsp) rsp_budget--;
        obi_rvalid_i = 1'b1;
        obi_err_i    = pend[0].err;
        void'(pend.pop_front());
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    gaddr.delete();
    gdata.delete();
    gbe.delete();
    rsps.delete();
    bidx       = 0;
    err_at     = -1;
    buf_data_i = pat(0);
    buf_strb_i = spat(0);
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [7:0] l, input string nm);
    bit hs = 1'b0;
    aw_addr_i  = a;
    aw_len_i   = l;
    aw_valid_i = 1'b1;
    for (int k = 0; k < 100 && !hs; k++) begin
      @(negedge clk);
      if (aw_ready_o) hs = 1'b1;
      step();
    end
    aw_valid_i = 1'b0;
    chk(nm, 64'(hs), 64'd1);
  endtask

  task automatic wait_rsp(input int n, input string nm);
    int k = 0;
    while (int'(rsps.size()) < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 64'(int'(rsps.size()) >= n), 64'd1);
    step();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          err_at;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin : main
    bit seen;
    vecs[0] = '{32'h0000_1003, 8'd0, -1, 32'h0000_1000, 32'h0000_1000, 1'b0};
    vecs[1] = '{32'h0000_0020, 8'd3,  2, 32'h0000_0020, 32'h0000_002C, 1'b1};
    vecs[2] = '{32'hFFFF_FFFE, 8'd1, -1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h0000_0105, 8'd5,  0, 32'h0000_0104, 32'h0000_0118, 1'b1};

    rst_ni = 1'b0;
    aw_addr_i = '0; aw_len_i = '0; aw_valid_i = 1'b0;
    buf_valid_i = 1'b1; dp_poison_i = 1'b0;
    obi_gnt_i = 1'b1; obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
    w_rsp_ready_i = 1'b1;
    clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", 64'(aw_ready_o), 64'd0);
    chk("rst_req", 64'(obi_req_o), 64'd0);
    chk("rst_we", 64'(obi_we_o), 64'd1);
    chk("rst_wdata", 64'(obi_wdata_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_wrsp", 64'(w_rsp_valid_o), 64'd0);
    step();
    rst_ni = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      clear_logs();
      err_at = vecs[v].err_at;
      do_aw(vecs[v].addr, vecs[v].len, $sformatf("v%0d_aw", v));
      wait_rsp(1, $sformatf("v%0d_rsp_seen", v));
      chk($sformatf("v%0d_beats", v), 64'(gaddr.size()), 64'(int'(vecs[v].len) + 1));
      chk($sformatf("v%0d_first_addr", v), 64'(gaddr[0]), 64'(vecs[v].exp_first));
      chk($sformatf("v%0d_last_addr", v), 64'(gaddr[gaddr.size() - 1]), 64'(vecs[v].exp_last));
      chk($sformatf("v%0d_data0", v), 64'(gdata[0]), 64'(pat(0)));
      chk($sformatf("v%0d_be_last", v), 64'(gbe[gbe.size() - 1]), 64'(spat(int'(vecs[v].len))));
      chk($sformatf("v%0d_rsp_err", v), 64'(rsps[0]), 64'(vecs[v].exp_err));
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", v), 64'(busy_o), 64'd0);
      chk($sformatf("v%0d_rsp_count", v), 64'(rsps.size()), 64'd1);
      step();
    end

    // Outstanding limit: responses withheld, then released one at a time.
    clear_logs();
    hold_rsp = 1'b1;
    rsp_budget = 0;
    do_aw(32'h0, 8'd7, "ost_aw");
    repeat (10) step();
    @(negedge clk);
    chk("ost_grants4", 64'(gaddr.size()), 64'd4);
    chk("ost_addr0", 64'(gaddr[0]), 64'h0);
    chk("ost_addr1", 64'(gaddr[1]), 64'h4);
    chk("ost_addr2", 64'(gaddr[2]), 64'h8);
    chk("ost_addr3", 64'(gaddr[3]), 64'hC);
    chk("ost_req_low", 64'(obi_req_o), 64'd0);
    step();
    rsp_budget = 1;
    repeat (5) step();
    @(negedge clk);
    chk("ost_grants5", 64'(gaddr.size()), 64'd5);
    chk("ost_req_low2", 64'(obi_req_o), 64'd0);
    chk("ost_no_early_rsp", 64'(rsps.size()), 64'd0);
    step();
    hold_rsp = 1'b0;
    wait_rsp(1, "ost_rsp_seen");
    chk("ost_grants8", 64'(gaddr.size()), 64'd8);
    chk("ost_addr7", 64'(gaddr[7]), 64'h1C);
    chk("ost_rsp_err", 64'(rsps[0]), 64'd0);

    // Poison and stall on beat 1.
    clear_logs();
    obi_gnt_i = 1'b0;
    do_aw(32'h300, 8'd2, "psn_aw");
    obi_gnt_i = 1'b1;
    step();
    obi_gnt_i = 1'b0;
    dp_poison_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("psn_req_%0d", i), 64'(obi_req_o), 64'd1);
      chk($sformatf("psn_addr_%0d", i), 64'(obi_addr_o), 64'h304);
      chk($sformatf("psn_data_%0d", i), 64'(obi_wdata_o), 64'(pat(1)));
      chk($sformatf("psn_be_%0d", i), 64'(obi_be_o), 64'h0);
      chk($sformatf("psn_bufrdy_%0d", i), 64'(buf_ready_o), 64'd0);
      step();
    end
    obi_gnt_i = 1'b1;
    @(negedge clk);
    chk("psn_bufrdy_gnt", 64'(buf_ready_o), 64'd1);
    step();
    dp_poison_i = 1'b0;
    wait_rsp(1, "psn_rsp_seen");
    chk("psn_beats", 64'(gbe.size()), 64'd3);
    chk("psn_be1", 64'(gbe[1]), 64'h0);
    chk("psn_be2", 64'(gbe[2]), 64'(spat(2)));
    chk("psn_be0", 64'(gbe[0]), 64'(spat(0)));

    // Queueing with completion backpressure.
    clear_logs();
    w_rsp_ready_i = 1'b0;
    do_aw(32'h400, 8'd1, "q_aw1");
    do_aw(32'h500, 8'd1, "q_aw2");
    aw_addr_i = 32'h600;
    aw_len_i = 8'd1;
    aw_valid_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (aw_ready_o) seen = 1'b1;
      step();
    end
    aw_valid_i = 1'b0;
    chk("q_aw3_held", 64'(seen), 64'd0);
    chk("q_grants4", 64'(gaddr.size()), 64'd4);
    w_rsp_ready_i = 1'b1;
    step();
    w_rsp_ready_i = 1'b0;
    chk("q_one_rsp", 64'(rsps.size()), 64'd1);
    do_aw(32'h600, 8'd1, "q_aw3_accept");
    w_rsp_ready_i = 1'b1;
    wait_rsp(3, "q_rsp3_seen");
    chk("q_addr_t3", 64'(gaddr[4]), 64'h600);
    chk("q_rsp_errs", 64'({rsps[0], rsps[1], rsps[2]}), 64'd0);

    // Reset in the middle of a five-beat burst.
    clear_logs();
    hold_rsp = 1'b1;
    rsp_budget = 0;
    do_aw(32'h200, 8'd4, "rb_aw");
    step();
    step();
    rst_ni = 1'b0;
    @(negedge clk);
    chk("rb_grants2", 64'(gaddr.size()), 64'd2);
    chk("rb_req_in_rst", 64'(obi_req_o), 64'd0);
    step();
    stray = 1'b1;
    @(negedge clk);
    chk("rb_req", 64'(obi_req_o), 64'd0);
    chk("rb_aw_ready", 64'(aw_ready_o), 64'd0);
    chk("rb_buf_ready", 64'(buf_ready_o), 64'd0);
    chk("rb_addr", 64'(obi_addr_o), 64'd0);
    chk("rb_be", 64'(obi_be_o), 64'd0);
    chk("rb_wdata", 64'(obi_wdata_o), 64'd0);
    chk("rb_wrsp", 64'(w_rsp_valid_o), 64'd0);
    chk("rb_busy", 64'(busy_o), 64'd0);
    chk("rb_we", 64'(obi_we_o), 64'd1);
    step();
    rst_ni = 1'b1;
    pend.delete();
    hold_rsp = 1'b0;
    @(negedge clk);
    chk("rb_busy_after", 64'(busy_o), 64'd0);
    chk("rb_aw_ready_after", 64'(aw_ready_o), 64'd1);
    step();
    clear_logs();
    do_aw(32'h40, 8'd1, "rb_fresh_aw");
    wait_rsp(1, "rb_fresh_rsp");
    chk("rb_fresh_beats", 64'(gaddr.size()), 64'd2);
    chk("rb_fresh_addr", 64'(gaddr[1]), 64'h44);
    chk("rb_fresh_err", 64'(rsps[0]), 64'd0);
    @(negedge clk);
    chk("rb_fresh_idle", 64'(busy_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idma_obi_write_outstanding.md
Name: idma_obi_write_outstanding

Overview:
Next-generation OBI write port for the iDMA transport layer, generalised in width, outstanding depth and transfer queueing. It takes a write meta request (start address, beat count) and issues one OBI write per beat, sourcing data and byte enables from the dataflow buffer. Up to NumOutstanding beats may be in flight without waiting for responses. Up to NumTransfers transfers are tracked, and each transfer returns one response carrying an accumulated error flag.

Parameters:
DataWidth, 32, OBI data width in bits; multiple of 8; StrbWidth = DataWidth/8
AddrWidth, 32, OBI address width
LenWidth, 8, width of the beat-count field (beats = len+1)
NumOutstanding, 4, maximum granted-but-unanswered OBI beats; >=1
NumTransfers, 2, maximum accepted transfers whose response has not yet been delivered; >=1
MaskInvalidData, 1, drive wdata/be to 0 whenever obi_req_o is low

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
aw_addr_i  in  AddrWidth  transfer start address
aw_len_i  in  LenWidth  beats minus one
aw_valid_i  in  1  meta valid
aw_ready_o  out  1  meta ready
buf_data_i  in  DataWidth  aligned buffer beat
buf_strb_i  in  StrbWidth  byte enables of the beat
buf_valid_i  in  1  buffer beat valid
buf_ready_o  out  1  buffer beat consumed
dp_poison_i  in  1  force be=0 on the beat granted this cycle
obi_req_o  out  1  OBI request
obi_gnt_i  in  1  OBI grant
obi_addr_o  out  AddrWidth  word-aligned beat address
obi_we_o  out  1  constant 1
obi_be_o  out  StrbWidth  byte enables
obi_wdata_o  out  DataWidth  write data
obi_rvalid_i  in  1  OBI response valid
obi_err_i  in  1  OBI response error
w_rsp_valid_o  out  1  transfer completion valid
w_rsp_ready_i  in  1  completion ready
w_rsp_err_o  out  1  OR of obi_err_i over all beats of the transfer
busy_o  out  1  any transfer, beat or response pending

Behaviour:
- Reset: every register clears on a clk_i edge while rst_ni=0.
  - During reset all outputs are 0 except obi_we_o=1.
  - Reset mid-burst drops all state.
  - obi_rvalid_i arriving with the outstanding count at 0 is ignored; a simulation assertion fires.
- Issue FSM, states IDLE and BURST:
  - IDLE: aw_ready_o = (len_fifo_cnt + cpl_fifo_cnt < NumTransfers).
  - On aw handshake: addr_q <= aw_addr_i with the low log2(StrbWidth) bits cleared; beats_left_q <= aw_len_i; push aw_len_i into len FIFO; go to BURST. aw_ready_o is 0 in BURST.
  - BURST: obi_req_o = buf_valid_i & (outstanding < NumOutstanding).
  - The request, once raised, stays stable until grant; a stalled request holds the outstanding count, so this is guaranteed.
  - obi_addr_o = addr_q; obi_wdata_o = buf_data_i; obi_be_o = dp_poison_i ? 0 : buf_strb_i.
  - buf_ready_o = obi_req_o & obi_gnt_i (combinational).
  - On grant: addr_q += StrbWidth (wraps modulo 2^AddrWidth); beats_left_q -= 1.
  - Grant with beats_left_q==0 returns to IDLE. New meta is accepted from the next cycle, so back-to-back transfers have one bubble cycle.
- Outstanding counter, width $clog2(NumOutstanding+1): +1 on grant, -1 on rvalid, unchanged when both occur in the same cycle.
- Response tracker:
  - rsp_cnt_q counts rvalids against the head of the len FIFO; err_acc_q |= obi_err_i on each rvalid.
  - When rvalid arrives with rsp_cnt_q == head: pop len FIFO; push (err_acc_q | obi_err_i) into the completion FIFO (depth NumTransfers); clear rsp_cnt_q and err_acc_q.
  - The aw_ready_o admission rule guarantees the completion FIFO never overflows; assert on push-when-full.
  - w_rsp_valid_o = completion FIFO not empty; w_rsp_err_o = its head; pop on w_rsp handshake.
  - Response latency: w_rsp_valid_o rises the cycle after the final rvalid.
- busy_o = (state==BURST) | (outstanding!=0) | len FIFO not empty | completion FIFO not empty.
- A transfer with len=0 issues exactly one beat.
- Errors do not abort the transfer; all beats are still written.

Decomposition:
- Package idma_obi_write_pkg holds:
  - addr_t, len_t, strb_t, data_t typedefs parametrised by the defaults;
  - the issue-FSM state enum;
  - StrbWidth and AddrLsb localparams.
- Len FIFO and completion FIFO use common_cells fifo_v3 (FALL_THROUGH=0).
- One natural sub-module, idma_obi_rsp_tracker, contains: the len FIFO, rsp_cnt, err_acc, the completion FIFO, and the completion handshake.

Test Plan:
- Single beat: aw_addr=0x1003, len=0; buffer data 0xDEADBEEF, strb 0xF; gnt immediate; rvalid 2 cycles later with err=0. Expect obi_addr 0x1000, be 0xF, one w_rsp with err=0, busy_o low afterwards.
- Outstanding limit: NumOutstanding=4, len=7, gnt always 1, rvalid withheld. Expect exactly 4 grants at addr 0x0,0x4,0x8,0xC, then obi_req_o=0. Each later rvalid allows exactly one more grant; one w_rsp after the 8th rvalid.
- Error accumulation: len=3, err=1 on beat 2 only. Expect a single w_rsp with err=1 and all 4 beats written.
- Queueing and backpressure: NumTransfers=2, w_rsp_ready_i=0, three transfers with len=1. Expect the third aw held (aw_ready_o=0) until one w_rsp handshake occurs, then accepted.
- Poison and stall: dp_poison_i=1 on beat 1 of len=2 with gnt low for 3 cycles. Expect req/addr/data stable across the stall, be=0 for that beat, and the buffer beat consumed only on grant.
- Reset mid-burst: assert rst_ni=0 after 2 of 5 grants. Expect all outputs 0 on the next edge. A stray rvalid after reset is ignored, and a fresh transfer completes normally.
